riscv_fetch_unit: RTL and testbench



---
 rtl/riscv_fetch_unit.sv | 174 +++++++++++++++++
 tb/tb_riscv_fetch_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch unit: request/grant/response memory port feeding a prefetch FIFO.
// Optional FETCH_ERR_EN adds imem_err_i / instr_err_o and halts fetch after a bus error.

module riscv_fetch_unit #(
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              instr_valid_o,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    input  logic              instr_ready_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
`ifdef FETCH_ERR_EN
    input  logic              imem_err_i,
    output logic              instr_err_o,
`endif
    input  logic [31:0]       imem_rdata_i
);

    localparam int unsigned       PTR_W       = $clog2(DEPTH);
    localparam int unsigned       CNT_W       = PTR_W + 1;
    localparam int unsigned       CSUM_W      = CNT_W + 1;
    localparam logic [ADDR_W-1:0] PC_STEP     = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] RESET_PC_AL = {RESET_PC[ADDR_W-1:2], 2'b00};
    localparam logic [31:0]       NOP_INSTR   = 32'h0000_0013;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [ADDR_W-1:0] redirect_pc_al;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  discard_q, discard_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [31:0]       mem_data_q [DEPTH];
    logic [ADDR_W-1:0] mem_pc_q   [DEPTH];
    logic [CSUM_W-1:0] credit_sum;
    logic              pop;
    logic              gnt_fire;
    logic              rsp_ok;
    logic              push;
    logic              rsp_err;
    logic              halt;
    logic [31:0]       push_data;

`ifdef FETCH_ERR_EN
    logic mem_err_q [DEPTH];
    logic err_stop_q, err_stop_d;

    assign rsp_err     = imem_err_i;
    assign halt        = err_stop_q;
    assign instr_err_o = mem_err_q[rd_ptr_q];
`else
    assign rsp_err = 1'b0;
    assign halt    = 1'b0;
`endif

    assign redirect_pc_al = {redirect_pc_i[ADDR_W-1:2], 2'b00};
    assign instr_valid_o  = (count_q != '0);
    assign instr_o        = mem_data_q[rd_ptr_q];
    assign instr_pc_o     = mem_pc_q[rd_ptr_q];
    assign imem_addr_o    = fetch_pc_q;

    always_comb begin
        pop        = instr_valid_o & instr_ready_i;
        // Credits cover both buffered entries and in-flight requests, so the FIFO cannot overflow.
        credit_sum = CSUM_W'(count_q) + CSUM_W'(outstanding_q) - CSUM_W'(pop);
        // Held low during reset so the memory never grants a request we would forget.
        imem_req_o = arstn_i & ~redirect_i & ~halt & (credit_sum < CSUM_W'(DEPTH));
        gnt_fire   = imem_req_o & imem_gnt_i;
        // A response with nothing outstanding is a protocol error and is ignored.
        rsp_ok     = imem_rvalid_i & (outstanding_q != '0);
        push       = rsp_ok & (discard_q == '0) & ~redirect_i;
        push_data  = rsp_err ? NOP_INSTR : imem_rdata_i;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + CNT_W'(gnt_fire) - CNT_W'(rsp_ok);

        if (redirect_i) begin
            fetch_pc_d = redirect_pc_al;
            resp_pc_d  = redirect_pc_al;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            // Outstanding already includes responses queued for discard.
            discard_d  = outstanding_q - CNT_W'(rsp_ok);
        end else begin
            if (gnt_fire) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (push) begin
                resp_pc_d = resp_pc_q + PC_STEP;
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (rsp_ok && (discard_q != '0)) begin
                discard_d = discard_q - CNT_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

`ifdef FETCH_ERR_EN
    always_comb begin
        err_stop_d = err_stop_q;
        if (redirect_i) begin
            err_stop_d = 1'b0;
        end else if (push && rsp_err) begin
            err_stop_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            err_stop_q <= 1'b0;
            mem_err_q  <= '{default: 1'b0};
        end else begin
            err_stop_q <= err_stop_d;
            if (push) begin
                mem_err_q[wr_ptr_q] <= rsp_err;
            end
        end
    end
`endif

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            fetch_pc_q    <= RESET_PC_AL;
            resp_pc_q     <= RESET_PC_AL;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Storage is reset so the head outputs read 0 / RESET_PC out of reset.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            mem_data_q <= '{default: '0};
            mem_pc_q   <= '{default: RESET_PC};
        end else if (push) begin
            mem_data_q[wr_ptr_q] <= push_data;
            mem_pc_q[wr_ptr_q]   <= resp_pc_q;
        end
    end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Scoreboard bench for riscv_fetch_unit: memory model with programmable latency and
// directed scenarios; a monitor pops expected {pc, instr, err} on every handshake.

module tb_riscv_fetch_unit;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              arstn;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              instr_valid;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;
    logic              mem_err;
    logic              instr_err;

    logic              gnt_en;
    int                lat;
    logic              err_arm;
    logic [31:0]       err_addr;

    int checks   = 0;
    int failures = 0;
    int n_pop    = 0;
    int n_gnt    = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
        logic        err;
    } rsp_t;

    exp_t exp_q[$];
    rsp_t pend_q[$];

    always #5 clk = ~clk;

    assign imem_gnt = gnt_en;

    riscv_fetch_unit #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk_i        (clk),
        .arstn_i      (arstn),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .instr_valid_o(instr_valid),
        .instr_o      (instr),
        .instr_pc_o   (instr_pc),
        .instr_ready_i(instr_ready),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_gnt_i   (imem_gnt),
        .imem_rvalid_i(imem_rvalid),
`ifdef FETCH_ERR_EN
        .imem_err_i   (mem_err),
        .instr_err_o  (instr_err),
`endif
        .imem_rdata_i (imem_rdata)
    );

`ifndef FETCH_ERR_EN
    assign instr_err = 1'b0;
`endif

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{pc: base + 32'(4 * i), instr: mem_word(base + 32'(4 * i)), err: 1'b0});
        end
    endtask

    task automatic do_reset();
        arstn    = 1'b0;
        redirect = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", instr_pc, 32'd0);
        tick();
        exp_q.delete();
    endtask

    // Memory: grants sampled mid-cycle, responses presented in order after `lat` cycles.
    always begin
        @(negedge clk);
        if (arstn && imem_req && imem_gnt) begin
            pend_q.push_back('{addr: imem_addr, due: cyc + lat,
                               err: err_arm && (imem_addr == err_addr)});
            n_gnt++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!arstn) begin
            pend_q.delete();
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
            mem_err     = 1'b0;
        end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_q[0].addr);
            mem_err     = pend_q[0].err;
            void'(pend_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
            mem_err     = 1'b0;
        end
    end

    // Monitor: a pop in a redirect cycle is void, so it is not scored.
    always begin
        exp_t e;
        @(negedge clk);
        if (arstn && instr_valid && instr_ready && !redirect) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_instr actual_pc=%h expected=none", instr_pc);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", instr_pc, e.pc);
                check("sb_instr", instr, e.instr);
`ifdef FETCH_ERR_EN
                check("sb_err", 32'(instr_err), 32'(e.err));
`endif
            end
        end
    end

    initial begin
        arstn       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        gnt_en      = 1'b0;
        lat         = 1;
        err_arm     = 1'b0;
        err_addr    = '0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        mem_err     = 1'b0;

        // 1: zero-wait streaming from reset
        instr_ready = 1'b1;
        gnt_en      = 1'b1;
        do_reset();
        push_seq(32'h0, 20);
        arstn = 1'b1;
        n_pop = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t1_req", 32'(imem_req), 32'd1);
            check("t1_addr", imem_addr, 32'(4 * k));
            check("t1_valid", 32'(instr_valid), (k >= 2) ? 32'd1 : 32'd0);
            tick();
        end
        repeat (6) tick();
        check("t1_pops", n_pop, 32'd8);
        instr_ready = 1'b0;

        // 2: credit limit with a stalled consumer
        gnt_en = 1'b1;
        do_reset();
        push_seq(32'h0, 6);
        n_gnt = 0;
        arstn = 1'b1;
        repeat (12) tick();
        check("t2_grants", n_gnt, 32'd4);
        @(negedge clk);
        check("t2_req_off", 32'(imem_req), 32'd0);
        check("t2_valid", 32'(instr_valid), 32'd1);
        tick();
        instr_ready = 1'b1;
        @(negedge clk);
        check("t2_resume_req", 32'(imem_req), 32'd1);
        check("t2_resume_addr", imem_addr, 32'h10);
        tick();
        repeat (5) tick();
        instr_ready = 1'b0;
        check("t2_drained", exp_q.size(), 32'd0);

        // 3: grant withheld, request held stable
        instr_ready = 1'b1;
        gnt_en      = 1'b1;
        do_reset();
        push_seq(32'h0, 16);
        arstn = 1'b1;
        tick();
        tick();
        gnt_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t3_req", 32'(imem_req), 32'd1);
            check("t3_addr", imem_addr, 32'h8);
            tick();
        end
        gnt_en = 1'b1;
        @(negedge clk);
        check("t3_addr_held", imem_addr, 32'h8);
        tick();
        @(negedge clk);
        check("t3_addr_next", imem_addr, 32'hC);
        repeat (4) tick();
        instr_ready = 1'b0;

        // 4: latency 3, two in flight, misaligned redirect
        instr_ready = 1'b1;
        gnt_en      = 1'b1;
        lat         = 3;
        do_reset();
        n_gnt = 0;
        arstn = 1'b1;
        tick();
        tick();
        gnt_en      = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        exp_q.delete();
        push_seq(32'h100, 16);
        n_pop = 0;
        @(negedge clk);
        check("t4_grants", n_gnt, 32'd2);
        check("t4_req_redirect", 32'(imem_req), 32'd0);
        tick();
        redirect = 1'b0;
        gnt_en   = 1'b1;
        @(negedge clk);
        check("t4_req", 32'(imem_req), 32'd1);
        check("t4_addr", imem_addr, 32'h100);
        tick();
        repeat (10) tick();
        check("t4_pops", n_pop, 32'd7);
        instr_ready = 1'b0;
        lat         = 1;

        // 5: redirect coincides with rvalid and pop, one outstanding
        instr_ready = 1'b1;
        gnt_en      = 1'b1;
        do_reset();
        arstn = 1'b1;
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        exp_q.delete();
        push_seq(32'h200, 8);
        @(negedge clk);
        check("t5_req_redirect", 32'(imem_req), 32'd0);
        check("t5_valid_at_n", 32'(instr_valid), 32'd1);
        check("t5_rvalid_at_n", 32'(imem_rvalid), 32'd1);
        tick();
        redirect = 1'b0;
        @(negedge clk);
        check("t5_addr", imem_addr, 32'h200);
        check("t5_valid_n1", 32'(instr_valid), 32'd0);
        tick();
        @(negedge clk);
        check("t5_valid_n2", 32'(instr_valid), 32'd0);
        tick();
        @(negedge clk);
        check("t5_valid_n3", 32'(instr_valid), 32'd1);
        check("t5_first_pc", instr_pc, 32'h200);
        repeat (3) tick();
        instr_ready = 1'b0;

`ifdef FETCH_ERR_EN
        // 6: bus error at 0x20 halts fetch until redirect
        instr_ready = 1'b1;
        gnt_en      = 1'b1;
        err_arm     = 1'b1;
        err_addr    = 32'h20;
        do_reset();
        push_seq(32'h0, 8);
        exp_q.push_back('{pc: 32'h20, instr: 32'h0000_0013, err: 1'b1});
        exp_q.push_back('{pc: 32'h24, instr: mem_word(32'h24), err: 1'b0});
        n_gnt = 0;
        arstn = 1'b1;
        repeat (10) tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t6_halted", 32'(imem_req), 32'd0);
            tick();
        end
        check("t6_grants", n_gnt, 32'd10);
        check("t6_drained", exp_q.size(), 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        exp_q.delete();
        push_seq(32'h40, 16);
        tick();
        redirect = 1'b0;
        @(negedge clk);
        check("t6_resume_req", 32'(imem_req), 32'd1);
        check("t6_resume_addr", imem_addr, 32'h40);
        tick();
        repeat (6) tick();
        instr_ready = 1'b0;
        err_arm     = 1'b0;
`endif

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
